conv_window_sequencer: RTL

- Sequences the sign-magnitude mantissa multiplier across a KERNEL_SIZE x KERNEL_SIZE window for every valid output position of a COLUMNS x ROWS image.
- Issues image and kernel buffer reads, drives the multiplier operands, and accumulates the signed products.
- Emits one accumulated result per output pixel over a valid/ready handshake.
- Sits between the image/kernel buffers and the downstream normalisation stage of the convolution engine.

---
 rtl/conv_pkg.sv | 26 ++
 rtl/conv_window_sequencer_mult.sv | 17 +
 rtl/conv_window_sequencer.sv | 134 +++++++++++++
 3 files changed

// File: rtl/conv_pkg.sv
// Shared widths, FSM state encoding and sign-magnitude helpers for the
// convolution window sequencer.
package conv_pkg;

  localparam int MANT_SIZE   = 10;
  localparam int EXP_SIZE    = 5;
  localparam int KERNEL_SIZE = 3;
  localparam int ACC_W       = 2*MANT_SIZE+5;
  localparam int PROD_W      = 2*MANT_SIZE+1;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DRAIN,
    OUT,
    DONE
  } state_t;

  // Negative zero maps to 0 because -0 == 0 in two's complement.
  function automatic logic [ACC_W-1:0] sm_to_tc(input logic [PROD_W-1:0] p);
    logic [ACC_W-1:0] mag;
    mag = {{(ACC_W-PROD_W+1){1'b0}}, p[PROD_W-2:0]};
    return p[PROD_W-1] ? -mag : mag;
  endfunction

endpackage

// File: rtl/conv_window_sequencer_mult.sv
// Combinational sign-magnitude mantissa multiplier: sign in the MSB of each
// operand and of the product.
module conv_window_sequencer_mult #(
  parameter int MANT_SIZE = 10
) (
  input  logic [MANT_SIZE:0]   a,
  input  logic [MANT_SIZE:0]   b,
  output logic [2*MANT_SIZE:0] prod
);

  logic [2*MANT_SIZE-1:0] mag;

  // Operands are widened first so the product is not truncated to MANT_SIZE.
  assign mag  = {{MANT_SIZE{1'b0}}, a[MANT_SIZE-1:0]} * {{MANT_SIZE{1'b0}}, b[MANT_SIZE-1:0]};
  assign prod = {a[MANT_SIZE] ^ b[MANT_SIZE], mag};

endmodule

// File: rtl/conv_window_sequencer.sv
// Walks a KERNEL_SIZE x KERNEL_SIZE window over every valid output position,
// reading image/kernel buffers and accumulating signed products per pixel.
module conv_window_sequencer
  import conv_pkg::*;
#(
  parameter int MANT_SIZE   = conv_pkg::MANT_SIZE,
  parameter int KERNEL_SIZE = conv_pkg::KERNEL_SIZE,
  parameter int COLUMNS     = 4,
  parameter int ROWS        = 4,
  parameter int ADDR_SIZE   = 4,
  parameter int KADDR_SIZE  = 4,
  parameter int ACC_W       = conv_pkg::ACC_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  img_rd_en,
  output logic [ADDR_SIZE-1:0]  img_addr,
  input  logic [MANT_SIZE:0]    img_data,
  output logic                  ker_rd_en,
  output logic [KADDR_SIZE-1:0] ker_addr,
  input  logic [MANT_SIZE:0]    ker_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ACC_W-1:0]      out_data,
  output logic [ADDR_SIZE-1:0]  out_row,
  output logic [ADDR_SIZE-1:0]  out_col
);

  localparam logic [KADDR_SIZE-1:0] LAST_K = KADDR_SIZE'(KERNEL_SIZE-1);
  localparam logic [ADDR_SIZE-1:0]  LAST_C = ADDR_SIZE'(COLUMNS-KERNEL_SIZE);
  localparam logic [ADDR_SIZE-1:0]  LAST_R = ADDR_SIZE'(ROWS-KERNEL_SIZE);

  state_t state, state_nxt;

  logic [ADDR_SIZE-1:0]  r, c;
  logic [KADDR_SIZE-1:0] kr, kc;
  logic [ACC_W-1:0]      acc;
  logic                  prod_vld;
  logic [2*MANT_SIZE:0]  prod;
  logic                  last_tap, last_pos;

  assign last_tap = (kr == LAST_K) && (kc == LAST_K);
  assign last_pos = (r == LAST_R) && (c == LAST_C);

  conv_window_sequencer_mult #(.MANT_SIZE(MANT_SIZE)) u_mult (
    .a    (img_data),
    .b    (ker_data),
    .prod (prod)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (start) state_nxt = FETCH;
      FETCH: if (last_tap) state_nxt = DRAIN;
      DRAIN: state_nxt = OUT;
      OUT:   if (out_ready) state_nxt = last_pos ? DONE : FETCH;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign img_rd_en = (state == FETCH);
  assign ker_rd_en = (state == FETCH);
  assign out_valid = (state == OUT);

  assign img_addr = ADDR_SIZE'((r + ADDR_SIZE'(kr)) * ADDR_SIZE'(COLUMNS) + c + ADDR_SIZE'(kc));
  assign ker_addr = KADDR_SIZE'(kr * KADDR_SIZE'(KERNEL_SIZE) + kc);

  assign out_data = acc;
  assign out_row  = r;
  assign out_col  = c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r        <= '0;
      c        <= '0;
      kr       <= '0;
      kc       <= '0;
      acc      <= '0;
      prod_vld <= 1'b0;
    end else begin
      // Buffer data lands one cycle after the strobe, so the strobe delayed
      // by one cycle marks a valid product.
      prod_vld <= img_rd_en;
      if (prod_vld) acc <= acc + sm_to_tc(prod);

      unique case (state)
        IDLE: begin
          if (start) begin
            r   <= '0;
            c   <= '0;
            kr  <= '0;
            kc  <= '0;
            acc <= '0;
          end
        end
        FETCH: begin
          if (kc == LAST_K) begin
            kc <= '0;
            kr <= (kr == LAST_K) ? '0 : kr + 1'b1;
          end else begin
            kc <= kc + 1'b1;
          end
        end
        OUT: begin
          if (out_ready && !last_pos) begin
            acc <= '0;
            kr  <= '0;
            kc  <= '0;
            if (c == LAST_C) begin
              c <= '0;
              r <= r + 1'b1;
            end else begin
              c <= c + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
